// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the datapath widths, one-hot access-size indices, byte-mask
// constants, the MEM FSM state encoding and a size-to-mask helper.
package mem_access_stage_pkg;

  localparam int P_XLEN    = 64;
  localparam int P_REGID_W = 5;

  // Bit positions inside the one-hot wdt_op size field
  localparam int WDT_B = 0;
  localparam int WDT_H = 1;
  localparam int WDT_W = 2;
  localparam int WDT_D = 3;

  // Byte enables for a lane-0 access of each size
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } mem_state_e;

  // Lane-0 byte mask for a one-hot size; an empty size gives no enables
  function automatic logic [7:0] size_mask(input logic [3:0] wdt);
    logic [7:0] m;
    m = 8'h00;
    if (wdt[WDT_D])      m = MASK_D;
    else if (wdt[WDT_W]) m = MASK_W;
    else if (wdt[WDT_H]) m = MASK_H;
    else if (wdt[WDT_B]) m = MASK_B;
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// lsu_align: purely combinational store/load lane alignment.
// Ports:
//   i_wdt_op    one-hot access size {D,W,H,B}
//   i_lane      byte lane inside the 8-byte word (addr[2:0])
//   i_unsigned  zero-extend loads instead of sign-extending
//   i_wdata     right-justified store data
//   i_rdata     raw 8-byte read data from the bus
//   o_st_wdata  store data replicated across every lane of its size
//   o_st_wmask  byte enables shifted to the addressed lane
//   o_ld_data   shifted, truncated and extended load result
module lsu_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = P_XLEN
) (
  input  logic [3:0]      i_wdt_op,
  input  logic [2:0]      i_lane,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_st_wdata,
  output logic [7:0]      o_st_wmask,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_sh;
  logic            w_sext;

  // Bring the addressed byte down to bit 0
  assign w_sh       = i_rdata >> {i_lane, 3'b000};
  assign o_st_wmask = size_mask(i_wdt_op) << i_lane;

  always_comb begin
    o_st_wdata = '0;
    o_ld_data  = '0;
    w_sext     = 1'b0;
    if (i_wdt_op[WDT_D]) begin
      // Doubleword fills the register, so signedness is irrelevant
      o_st_wdata = i_wdata;
      o_ld_data  = w_sh;
    end else if (i_wdt_op[WDT_W]) begin
      w_sext     = ~i_unsigned & w_sh[31];
      o_st_wdata = {2{i_wdata[31:0]}};
      o_ld_data  = {{32{w_sext}}, w_sh[31:0]};
    end else if (i_wdt_op[WDT_H]) begin
      w_sext     = ~i_unsigned & w_sh[15];
      o_st_wdata = {4{i_wdata[15:0]}};
      o_ld_data  = {{48{w_sext}}, w_sh[15:0]};
    end else if (i_wdt_op[WDT_B]) begin
      w_sext     = ~i_unsigned & w_sh[7];
      o_st_wdata = {8{i_wdata[7:0]}};
      o_ld_data  = {{56{w_sext}}, w_sh[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RV64 pipeline.
// Issues loads/stores on a req/gnt/rvalid data bus, stalls upstream while
// an access is outstanding and registers the retiring result into MEM/WB.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   *_MEM               EX/MEM register contents (held stable while stalled)
//   dmem_*              data-memory bus (req/we/addr/wdata/wmask out,
//                       gnt/rvalid/rdata in)
//   stall_MEM           hold EX/MEM and all earlier stages
//   wb_*, misalign,
//   pc_WB, inst_WB      registered MEM/WB outputs
//   dbg_state           current FSM state (IDLE=0, REQ=1, WAIT_R=2)
// Bus handshake: dmem_req is valid and dmem_gnt is ready; a request is
// accepted in the cycle both are high, and its address/data/mask stay stable
// from the first req cycle until that cycle. Read data arrives with
// dmem_rvalid at least one cycle after the granting cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN    = P_XLEN,
  parameter int REGID_W = P_REGID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_MEM,
  input  logic [REGID_W-1:0] rd_MEM,
  input  logic               ren_MEM,
  input  logic               wen_MEM,
  input  logic               unsigned_MEM,
  input  logic [3:0]         wdt_op_MEM,
  input  logic [XLEN-1:0]    alu_result_MEM,
  input  logic [XLEN-1:0]    wdata_MEM,
  input  logic [XLEN-1:0]    pc_MEM,
  input  logic [31:0]        inst_MEM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [7:0]         dmem_wmask,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               stall_MEM,
  output logic               wb_valid,
  output logic [REGID_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               wb_wen_rf,
  output logic               misalign,
  output logic [XLEN-1:0]    pc_WB,
  output logic [31:0]        inst_WB,
  output logic [1:0]         dbg_state
);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;
  logic            w_mem_op;
  logic            w_misalign;
  logic            w_access;
  logic            w_complete;
  logic [2:0]      w_lane;
  logic [XLEN-1:0] w_ld_data;

  assign w_lane   = alu_result_MEM[2:0];
  assign w_mem_op = ~flush_MEM & (ren_MEM | wen_MEM);

  // Bytes never misalign; each wider size needs its low address bits clear
  assign w_misalign = w_mem_op &
                      ((wdt_op_MEM[WDT_H] & w_lane[0]) |
                       (wdt_op_MEM[WDT_W] & (w_lane[1:0] != 2'b00)) |
                       (wdt_op_MEM[WDT_D] & (w_lane != 3'b000)));
  assign w_access   = w_mem_op & ~w_misalign;

  assign dmem_addr = {alu_result_MEM[XLEN-1:3], 3'b000};
  assign dmem_we   = dmem_req & wen_MEM;
  assign dbg_state = r_state;

  lsu_align #(.XLEN(XLEN)) u_lsu_align (
    .i_wdt_op   (wdt_op_MEM),
    .i_lane     (w_lane),
    .i_unsigned (unsigned_MEM),
    .i_wdata    (wdata_MEM),
    .i_rdata    (dmem_rdata),
    .o_st_wdata (dmem_wdata),
    .o_st_wmask (dmem_wmask),
    .o_ld_data  (w_ld_data)
  );

  // w_complete marks the cycle an instruction retires into WB; stall_MEM is
  // high in every other cycle of an unfinished access.
  always_comb begin
    w_state_nxt = r_state;
    dmem_req    = 1'b0;
    stall_MEM   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          dmem_req = 1'b1;
          if (dmem_gnt && wen_MEM) begin
            w_complete = 1'b1;
          end else if (dmem_gnt) begin
            stall_MEM   = 1'b1;
            w_state_nxt = ST_WAIT_R;
          end else begin
            stall_MEM   = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end else if (!flush_MEM && !w_mem_op) begin
          w_complete = 1'b1;
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt && wen_MEM) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dmem_gnt) begin
          stall_MEM   = 1'b1;
          w_state_nxt = ST_WAIT_R;
        end else begin
          stall_MEM = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (dmem_rvalid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          stall_MEM = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // The instruction still sitting in EX/MEM during reset must not reach
    // the bus or hold the pipeline.
    if (rst) begin
      dmem_req   = 1'b0;
      stall_MEM  = 1'b0;
      w_complete = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_wen_rf <= 1'b0;
      misalign  <= 1'b0;
      pc_WB     <= '0;
      inst_WB   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      wb_valid  <= w_complete;
      wb_rd     <= rd_MEM;
      wb_data   <= ren_MEM ? w_ld_data : alu_result_MEM;
      wb_wen_rf <= w_complete & ~wen_MEM & (rd_MEM != '0);
      misalign  <= w_misalign & (r_state == ST_IDLE);
      pc_WB     <= pc_MEM;
      inst_WB   <= inst_MEM;
    end
  end

endmodule
